// File: rtl/tick_scheduler.sv
// tick_scheduler
//
// Purpose:
//   Takes the toggling output of the clock divider, which is asynchronous to
//   clk, and passes it through a synchroniser. Each rising edge becomes a
//   one-cycle tick enable in the clk domain. Ticks are counted into periodic
//   event pulses. A small start/pause/stop FSM controls when ticks are issued.
//   Downstream logic uses tick and event_pulse only as clock enables.
//
// Ports:
//   clk             system clock; every flop updates on its rising edge
//   reset_n         asynchronous active-low reset
//   div_clk         divider output, treated as asynchronous
//   start           level; begin running from IDLE, or resume from PAUSE
//   pause           level; RUN -> PAUSE, or PAUSE -> RUN
//   stop            level; abort to IDLE from any state
//   steps_per_event ticks per event (N); latched on IDLE -> RUN, 0 becomes 1
//   tick            one-cycle pulse per qualified div_clk rising edge
//   event_pulse     one-cycle pulse on every Nth tick. It carries the "event"
//                   output; event itself is a SystemVerilog keyword.
//   tick_count      ticks since the last event, 0..N-1
//   event_count     events since start, wraps at 16'hFFFF
//   running         high in RUN
//   paused          high in PAUSE
//
// Control priority is stop > start > pause. div_clk must have a period of at
// least 2*(SYNC_STAGES+1) clk cycles, otherwise ticks may be missed.

module tick_scheduler #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             div_clk,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    input  logic [CNT_W-1:0] steps_per_event,
    output logic             tick,
    output logic             event_pulse,
    output logic [CNT_W-1:0] tick_count,
    output logic [15:0]      event_count,
    output logic             running,
    output logic             paused
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   tick_q, tick_d;
    logic                   event_q, event_d;
    logic [CNT_W-1:0]       tick_count_q, tick_count_d;
    logic [CNT_W-1:0]       n_q, n_d;
    logic [15:0]            event_count_q, event_count_d;

    logic rise;
    logic tick_ok;
    logic at_wrap;
    logic launch;

    // The synchroniser and the prev flop shift in every state. As a result,
    // a rise that happened while paused or idle has already been consumed
    // when running resumes.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], div_clk};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    assign rise    = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign launch  = (state_q == IDLE) && !stop && start;
    // stop overrides the tick in the same cycle. pause does not, so the
    // tick is issued and the FSM enters PAUSE afterwards.
    assign tick_ok = rise && (state_q == RUN) && !stop;
    assign at_wrap = (tick_count_q == (n_q - ONE));

    // Next-state logic. stop wins over everything. In PAUSE, start or pause
    // both resume, so a held pause bounces back to RUN on the next cycle.
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (pause) state_d = PAUSE;
                PAUSE:   if (start || pause) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Counter and pulse logic. A launch clears both counts and latches N.
    // Otherwise a qualified tick advances tick_count, or wraps it and emits
    // an event. stop leaves the counts untouched.
    always_comb begin
        tick_d        = tick_ok;
        event_d       = tick_ok && at_wrap;
        tick_count_d  = tick_count_q;
        event_count_d = event_count_q;
        n_d           = n_q;
        if (launch) begin
            tick_count_d  = '0;
            event_count_d = '0;
            n_d           = (steps_per_event == '0) ? ONE : steps_per_event;
        end else if (tick_ok) begin
            if (at_wrap) begin
                tick_count_d  = '0;
                event_count_d = event_count_q + 16'd1;
            end else begin
                tick_count_d  = tick_count_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            sync_q        <= '0;
            prev_q        <= 1'b0;
            tick_q        <= 1'b0;
            event_q       <= 1'b0;
            tick_count_q  <= '0;
            event_count_q <= '0;
            n_q           <= ONE;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            prev_q        <= prev_d;
            tick_q        <= tick_d;
            event_q       <= event_d;
            tick_count_q  <= tick_count_d;
            event_count_q <= event_count_d;
            n_q           <= n_d;
        end
    end

    assign tick        = tick_q;
    assign event_pulse = event_q;
    assign tick_count  = tick_count_q;
    assign event_count = event_count_q;
    assign running     = (state_q == RUN);
    assign paused      = (state_q == PAUSE);

endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Downstream consumer of the clock divider's toggling `clk_out`.
- Samples that signal in the system `clk` domain and converts each rising edge into a one-cycle `tick` enable.
- Counts ticks into periodic `event` pulses, under start/pause/stop control.
- Game logic uses `tick` and `event` as clock enables; `clk_out` is never used as a clock.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on `div_clk`; legal range 2..4.
- CNT_W, 8, width of `steps_per_event` and `tick_count`.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- div_clk  input  1  toggling output of the clock divider; treated as asynchronous.
- start  input  1  level, sampled each clk; begin or resume running.
- pause  input  1  level, sampled each clk; suspend or resume.
- stop  input  1  level, sampled each clk; abort to idle.
- steps_per_event  input  CNT_W  ticks per event; latched on IDLE->RUN.
- tick  output  1  one-cycle pulse per qualified `div_clk` rising edge.
- event  output  1  one-cycle pulse on every Nth tick.
- tick_count  output  CNT_W  ticks since the last event, range 0..N-1.
- event_count  output  16  events since start; wraps at 16'hFFFF.
- running  output  1  high in RUN.
- paused  output  1  high in PAUSE.

Behaviour:
- Reset (reset_n low, asynchronous):
  - sync chain, edge register and all counters clear to 0;
  - state = IDLE;
  - tick, event, running, paused = 0;
  - latched N = 1.
- Synchroniser and edge detect:
  - `div_clk` passes through SYNC_STAGES flops, then one `prev` flop.
  - edge = last_sync & ~prev.
  - The chain and `prev` update every cycle in every state, so resuming never produces a stale edge.
- Latency (SYNC_STAGES=2):
  - `div_clk` first sampled high at clk edge E0 gives tick high for exactly the one cycle after edge E2.
  - In general, tick follows E(SYNC_STAGES).
- States: IDLE, RUN, PAUSE. Control priority is stop > start > pause.
  - Any state, stop=1 -> IDLE. tick_count and event_count hold their values.
  - IDLE, start=1 -> RUN:
    - tick_count = 0, event_count = 0;
    - N = steps_per_event, with 0 coerced to 1.
  - RUN, pause=1 -> PAUSE.
  - PAUSE, start=1 or pause=1 -> RUN. Counters and N are retained.
  - pause and start are levels: holding pause in PAUSE returns to RUN on the next cycle.
  - The bench must drive control inputs as single-cycle pulses.
- Tick qualification:
  - tick = edge AND current state == RUN AND stop == 0.
  - An edge in the same cycle as pause is still issued; the state moves to PAUSE afterwards.
  - Edges seen in IDLE or PAUSE are discarded, not queued.
- Counting, on each tick:
  - If tick_count == N-1: event = 1 in the same cycle as tick, tick_count <= 0, event_count <= event_count + 1 (wraps to 0).
  - Otherwise: tick_count <= tick_count + 1.
  - With N = 1, every tick is an event.
- Changing `steps_per_event` in RUN or PAUSE has no effect until the next IDLE->RUN.
- tick and event are registered outputs, deasserted on every cycle not described above.
- Reset asserted mid-operation clears everything immediately, including an in-flight tick pulse.
- `div_clk` period must be at least 2*(SYNC_STAGES+1) clk cycles. Faster input is out of spec, and ticks may be missed.

Test Plan:
1. Reset, start pulse with steps_per_event=3, `div_clk` toggling every 8 clk -> tick every 16 clk, 3 clk after each `div_clk` rise; event on ticks 3, 6, 9; event_count = 3 after 9 ticks.
2. steps_per_event=0 at start -> N coerced to 1; event coincides with every tick; tick_count stays 0.
3. In RUN, pause across two `div_clk` rises, then start -> no tick while paused; tick_count unchanged; first tick after resume comes on the next fresh rise, not immediately.
4. stop and a qualifying edge in the same cycle -> no tick; state IDLE; running = 0; counters hold; next start clears both counts to 0.
5. Preload event_count to 16'hFFFF via 65535 events with N=1 at a fast legal `div_clk` rate -> next event wraps event_count to 0.
6. Assert reset_n=0 asynchronously while tick is high -> tick, event, running and counters go to 0 immediately, without waiting for a clk edge; after release, edges are ignored until start.
